bopit_round_scheduler: RTL and testbench

//   Sequences Bop-it game rounds on a slow time base: owns a clearable tick divider, runs

---
 rtl/bopit_pkg.sv | 31 +++
 rtl/bopit_round_scheduler_tick_gen.sv | 36 +++
 rtl/bopit_round_scheduler.sv | 158 +++++++++++++++
 tb/tb_bopit_round_scheduler.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bopit_pkg.sv
// Shared definitions for the Bop-it round scheduler and the scoring block.
//   state_e : scheduler states
//   LEVEL_W : level width, TICK_W : window width in ticks
//   limit() : reaction window length for a given level
package bopit_pkg;

  localparam int LEVEL_W = 4;
  localparam int TICK_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GAP    = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_OVER   = 2'd3
  } state_e;

  // max(start - lvl*step, min), evaluated in 12 bits so the subtraction
  // never wraps for any legal level/step combination.
  function automatic logic [TICK_W-1:0] limit(input logic [LEVEL_W-1:0] lvl,
                                              input logic [11:0]        start_t,
                                              input logic [11:0]        step_t,
                                              input logic [11:0]        min_t);
    logic [11:0] red;
    logic [11:0] res;
    red = 12'(lvl) * step_t;
    if (start_t >= red + min_t) res = start_t - red;
    else                        res = min_t;
    return res[TICK_W-1:0];
  endfunction

endpackage

// File: rtl/bopit_round_scheduler_tick_gen.sv
// Clearable slow-tick divider.
//   clk, rst_n : clock, async active-low reset
//   en         : count enable
//   clr        : synchronous clear (wins over en)
//   tick       : 1-cycle pulse when the count sits at DIV-1 while enabled
// tick is a function of the current count only, so the owner may derive clr
// from its next-state logic (which itself uses tick) without a loop.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr)       cnt_d = '0;
    else if (tick) cnt_d = '0;
    else if (en)   cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bopit_round_scheduler.sv
// Bop-it round scheduler: inter-round gaps, per-round reaction windows that
// shrink with level, and win/lose pulses for the game FSM.
//   clk, rst_n   : clock, async active-low reset
//   start        : pulse, begin a new game (IDLE/OVER only)
//   hit, miss    : pulses from debounced player inputs (ACTIVE only)
//   prompt_valid : pulse, round begins
//   round_active : reaction window open
//   success/fail : round won / lost pulses; timeout flags a lost-by-expiry
//   game_over    : high in OVER
//   level        : current level, ticks_left : remaining window ticks
module bopit_round_scheduler
  import bopit_pkg::*;
#(
  parameter int TICK_DIV    = 6_250_000,
  parameter int START_TICKS = 32,
  parameter int STEP_TICKS  = 2,
  parameter int MIN_TICKS   = 8,
  parameter int GAP_TICKS   = 8,
  parameter int MAX_LEVEL   = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hit,
  input  logic               miss,
  output logic               prompt_valid,
  output logic               round_active,
  output logic               success,
  output logic               fail,
  output logic               timeout,
  output logic               game_over,
  output logic [LEVEL_W-1:0] level,
  output logic [TICK_W-1:0]  ticks_left
);

  localparam int GAP_W = $clog2(GAP_TICKS + 1);
  localparam logic [GAP_W-1:0]   GAP_INIT = GAP_W'(GAP_TICKS);
  localparam logic [LEVEL_W-1:0] LVL_MAX  = LEVEL_W'(MAX_LEVEL);

  state_e             state_q, state_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [TICK_W-1:0]  ticks_left_q, ticks_left_d;
  logic               prompt_valid_q, prompt_valid_d;
  logic               round_active_q, round_active_d;
  logic               success_q, success_d;
  logic               fail_q, fail_d;
  logic               timeout_q, timeout_d;
  logic               game_over_q, game_over_d;

  logic tick, tick_en, tick_clr;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tick_en),
    .clr  (tick_clr),
    .tick (tick)
  );

  // Divider only runs while timing something; any state change restarts it so
  // each gap/window starts on a full tick period.
  assign tick_en  = (state_q == ST_GAP) || (state_q == ST_ACTIVE);
  assign tick_clr = (state_d != state_q);

  always_comb begin
    state_d        = state_q;
    gap_cnt_d      = gap_cnt_q;
    level_d        = level_q;
    ticks_left_d   = ticks_left_q;
    prompt_valid_d = 1'b0;
    success_d      = 1'b0;
    fail_d         = 1'b0;
    timeout_d      = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d   = ST_GAP;
          level_d   = '0;
          gap_cnt_d = GAP_INIT;
        end
      end
      ST_GAP: begin
        if (tick) begin
          if (gap_cnt_q == GAP_W'(1)) begin
            state_d        = ST_ACTIVE;
            prompt_valid_d = 1'b1;
            ticks_left_d   = limit(level_q, 12'(START_TICKS), 12'(STEP_TICKS), 12'(MIN_TICKS));
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
      end
      ST_ACTIVE: begin
        // miss beats hit, and a hit on the expiring tick still wins the round
        if (miss) begin
          state_d      = ST_OVER;
          fail_d       = 1'b1;
          ticks_left_d = '0;
        end else if (hit) begin
          state_d      = ST_GAP;
          success_d    = 1'b1;
          ticks_left_d = '0;
          gap_cnt_d    = GAP_INIT;
          level_d      = (level_q >= LVL_MAX) ? LVL_MAX : level_q + LEVEL_W'(1);
        end else if (tick) begin
          if (ticks_left_q == TICK_W'(1)) begin
            state_d      = ST_OVER;
            fail_d       = 1'b1;
            timeout_d    = 1'b1;
            ticks_left_d = '0;
          end else begin
            ticks_left_d = ticks_left_q - TICK_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    round_active_d = (state_d == ST_ACTIVE);
    game_over_d    = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      gap_cnt_q      <= '0;
      level_q        <= '0;
      ticks_left_q   <= '0;
      prompt_valid_q <= 1'b0;
      round_active_q <= 1'b0;
      success_q      <= 1'b0;
      fail_q         <= 1'b0;
      timeout_q      <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      gap_cnt_q      <= gap_cnt_d;
      level_q        <= level_d;
      ticks_left_q   <= ticks_left_d;
      prompt_valid_q <= prompt_valid_d;
      round_active_q <= round_active_d;
      success_q      <= success_d;
      fail_q         <= fail_d;
      timeout_q      <= timeout_d;
      game_over_q    <= game_over_d;
    end
  end

  assign prompt_valid = prompt_valid_q;
  assign round_active = round_active_q;
  assign success      = success_q;
  assign fail         = fail_q;
  assign timeout      = timeout_q;
  assign game_over    = game_over_q;
  assign level        = level_q;
  assign ticks_left   = ticks_left_q;

endmodule

// File: tb/tb_bopit_round_scheduler.sv
// Bench for bopit_round_scheduler: timeline-based reference model compared
// every cycle, directed scenarios with literal expectations, random traffic.
module tb_bopit_round_scheduler;

  localparam int DIV = 4, ST = 6, SP = 2, MN = 2, GP = 2, ML = 3;

  logic       clk = 1'b0, rst_n = 1'b1;
  logic       start = 1'b0, hit = 1'b0, miss = 1'b0;
  logic       prompt_valid, round_active, success, fail, timeout, game_over;
  logic [3:0] level;
  logic [7:0] ticks_left;

  bopit_round_scheduler #(
    .TICK_DIV(DIV), .START_TICKS(ST), .STEP_TICKS(SP),
    .MIN_TICKS(MN), .GAP_TICKS(GP), .MAX_LEVEL(ML)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit(hit), .miss(miss),
    .prompt_valid(prompt_valid), .round_active(round_active),
    .success(success), .fail(fail), .timeout(timeout),
    .game_over(game_over), .level(level), .ticks_left(ticks_left)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [17:0] outv();
    return {prompt_valid, round_active, success, fail, timeout, game_over, level, ticks_left};
  endfunction

  // ---------------- reference model ----------------
  // Works on edge numbers: a phase is remembered with the edge it began on;
  // deadlines and the remaining-tick count come from elapsed edges.
  typedef enum {P_IDLE, P_GAP, P_ACT, P_OVER} phase_t;
  phase_t ph = P_IDLE;
  int m_n = 0, m_e = 0, m_L = 0, m_lvl = 0;
  bit e_pv = 0, e_succ = 0, e_fail = 0, e_to = 0;

  function automatic int lim(input int l);
    int v;
    v = ST - l * SP;
    return (v < MN) ? MN : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = P_IDLE; m_n = 0; m_e = 0; m_L = 0; m_lvl = 0;
      e_pv = 0; e_succ = 0; e_fail = 0; e_to = 0;
    end else begin
      m_n++;
      e_pv = 0; e_succ = 0; e_fail = 0; e_to = 0;
      case (ph)
        P_IDLE, P_OVER:
          if (start) begin ph = P_GAP; m_e = m_n; m_lvl = 0; end
        P_GAP:
          if (m_n - m_e == GP * DIV) begin
            ph = P_ACT; m_e = m_n; m_L = lim(m_lvl); e_pv = 1;
          end
        P_ACT:
          if (miss) begin
            e_fail = 1; ph = P_OVER;
          end else if (hit) begin
            e_succ = 1; m_lvl = (m_lvl < ML) ? m_lvl + 1 : ML; ph = P_GAP; m_e = m_n;
          end else if (m_n - m_e == m_L * DIV) begin
            e_fail = 1; e_to = 1; ph = P_OVER;
          end
        default: ;
      endcase
    end
  end

  function automatic logic [17:0] expv();
    int tl;
    tl = (ph == P_ACT) ? m_L - (m_n - m_e) / DIV : 0;
    return {e_pv, ph == P_ACT, e_succ, e_fail, e_to, ph == P_OVER, 4'(m_lvl), 8'(tl)};
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (outv() !== expv()) begin
        errors++;
        $display("FAIL model_cmp: got %h expected %h (cycle %0d)", outv(), expv(), cyc);
      end
    end
  end

  // ---------------- directed helpers ----------------
  // which: 0 prompt_valid, 1 fail, 2 success
  task automatic wait_out(input int which, input string nm, output int at);
    logic s;
    at = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      s = (which == 0) ? prompt_valid : (which == 1) ? fail : success;
      if (s) begin at = cyc; break; end
    end
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL %s: got no pulse expected pulse within 300 cycles", nm);
    end
  endtask

  int s_edge, p, f, succ_cnt;
  int win[4] = '{6, 4, 2, 2};

  initial begin
    #1 rst_n = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", int'(outv()), 0);
    rst_n = 1'b1;

    // hit/miss in IDLE have no effect
    @(negedge clk) hit = 1'b1;
    @(negedge clk) begin hit = 1'b0; miss = 1'b1; end
    @(negedge clk) miss = 1'b0;
    @(negedge clk);
    chk("idle_ignore", int'(outv()), 0);

    // start, no response: prompt then timeout
    start = 1'b1; s_edge = cyc + 1;
    @(negedge clk) start = 1'b0;
    wait_out(0, "prompt_wait", p);
    chk("prompt_latency", p - s_edge, 8);
    chk("first_window", int'(ticks_left), 6);
    wait_out(1, "timeout_wait", f);
    chk("timeout_latency", f - p, 24);
    chk("timeout_flag", int'(timeout), 1);
    chk("over_flag", int'(game_over), 1);
    chk("over_level", int'(level), 0);

    // start from OVER, then win 4 rounds with hit 5 clk after each prompt
    start = 1'b1; s_edge = cyc + 1;
    @(negedge clk) start = 1'b0;
    chk("restart_level", int'(level), 0);
    chk("restart_over_clr", int'(game_over), 0);
    succ_cnt = 0;
    for (int r = 0; r < 4; r++) begin
      wait_out(0, "round_prompt", p);
      if (r == 0) chk("restart_latency", p - s_edge, 8);
      chk($sformatf("window_r%0d", r), int'(ticks_left), win[r]);
      repeat (4) @(negedge clk);
      hit = 1'b1;
      @(negedge clk) hit = 1'b0;
      if (success) succ_cnt++;
      if (r == 0) begin
        // miss during the gap is ignored
        @(negedge clk) miss = 1'b1;
        @(negedge clk) miss = 1'b0;
        chk("gap_miss_fail", int'(fail), 0);
        chk("gap_miss_over", int'(game_over), 0);
      end
    end
    chk("success_count", succ_cnt, 4);
    chk("level_saturated", int'(level), 3);

    // hit on the expiring tick wins
    wait_out(0, "edge_prompt", p);
    repeat (7) @(negedge clk);
    hit = 1'b1;
    @(negedge clk) hit = 1'b0;
    chk("edge_hit_success", int'(success), 1);
    chk("edge_hit_fail", int'(fail), 0);

    // hit+miss together loses, not by timeout
    wait_out(0, "both_prompt", p);
    repeat (2) @(negedge clk);
    hit = 1'b1; miss = 1'b1;
    @(negedge clk) begin hit = 1'b0; miss = 1'b0; end
    chk("both_fail", int'(fail), 1);
    chk("both_timeout", int'(timeout), 0);
    chk("both_success", int'(success), 0);

    // start during ACTIVE ignored, then async reset mid-window
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_out(0, "act_prompt", p);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("act_start_pv", int'(prompt_valid), 0);
    chk("act_start_active", int'(round_active), 1);
    chk("act_start_ticks", int'(ticks_left), 6);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", int'(outv()), 0);
    @(negedge clk) rst_n = 1'b1;

    // random traffic against the model
    repeat (3000) begin
      @(negedge clk);
      start = ($urandom_range(0, 39) == 0);
      hit   = ($urandom_range(0, 9) == 0);
      miss  = ($urandom_range(0, 59) == 0);
    end
    @(negedge clk) begin start = 1'b0; hit = 1'b0; miss = 1'b0; end
    @(negedge clk);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
